// File: rtl/imm_ext_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_stage_pkg
// Description : Shared CPU constants: datapath width default and ExtOp codes.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_ext_stage_pkg;

    localparam int c_data_w_default = 32;

    localparam logic [2:0] c_ext_zero_low    = 3'b000;
    localparam logic [2:0] c_ext_high        = 3'b001;
    localparam logic [2:0] c_ext_sign_low    = 3'b010;
    localparam logic [2:0] c_ext_sign_shift2 = 3'b011;
    localparam logic [2:0] c_ext_jump        = 3'b100;

    function automatic logic ext_op_legal(input logic [2:0] op);
        return (op <= c_ext_jump);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_core
// Description : Combinational immediate extension and branch/jump target add.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_core
    import imm_ext_stage_pkg::*;
#(
    parameter int DATA_W = c_data_w_default
) (
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc4,
    input  logic [2:0]        ext_op,
    output logic [DATA_W-1:0] ext_out,
    output logic [DATA_W-1:0] npc,
    output logic              illegal
);

    logic [15:0]       w_imm;
    logic [31:0]       w_hi32;
    logic [17:0]       w_sh2;
    logic [DATA_W-1:0] w_zx_lo;
    logic [DATA_W-1:0] w_sx_lo;
    logic [DATA_W-1:0] w_sx_hi;
    logic [DATA_W-1:0] w_sx_sh2;
    logic [DATA_W-1:0] w_jump;

    assign w_imm    = instr[15:0];
    assign w_hi32   = {w_imm, 16'h0000};
    assign w_sh2    = {w_imm, 2'b00};
    assign w_zx_lo  = DATA_W'(w_imm);
    // Size casts of signed operands sign-extend up to DATA_W.
    assign w_sx_lo  = DATA_W'($signed(w_imm));
    assign w_sx_hi  = DATA_W'($signed(w_hi32));
    assign w_sx_sh2 = DATA_W'($signed(w_sh2));
    assign w_jump   = {pc4[DATA_W-1:28], instr[25:0], 2'b00};

    always_comb begin
        ext_out = '0;
        npc     = '0;
        illegal = 1'b0;
        case (ext_op)
            c_ext_zero_low: begin
                ext_out = w_zx_lo;
                npc     = pc4 + w_zx_lo;
            end
            c_ext_high: begin
                ext_out = w_sx_hi;
                npc     = pc4 + w_sx_hi;
            end
            c_ext_sign_low: begin
                ext_out = w_sx_lo;
                npc     = pc4 + w_sx_lo;
            end
            c_ext_sign_shift2: begin
                ext_out = w_sx_sh2;
                npc     = pc4 + w_sx_sh2;
            end
            c_ext_jump: begin
                ext_out = w_jump;
                npc     = w_jump;
            end
            default: illegal = !ext_op_legal(ext_op);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_ext_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_stage
// Description : Immediate-extend stage with a small valid/ready output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_stage
    import imm_ext_stage_pkg::*;
#(
    parameter int DATA_W = c_data_w_default,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr_D,
    input  logic [DATA_W-1:0] PC4_D,
    input  logic [2:0]        ExtOp,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] EXTout,
    output logic [DATA_W-1:0] NPC_B,
    output logic              illegal_op
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

    logic [DATA_W-1:0]  r_ext_mem [DEPTH];
    logic [DATA_W-1:0]  r_npc_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_illegal;

    logic [DATA_W-1:0]  w_ext;
    logic [DATA_W-1:0]  w_npc;
    logic               w_illegal;
    logic               w_push;
    logic               w_pop;

    imm_ext_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .instr   (instr_D),
        .pc4     (PC4_D),
        .ext_op  (ExtOp),
        .ext_out (w_ext),
        .npc     (w_npc),
        .illegal (w_illegal)
    );

    assign out_valid  = (r_count != '0);
    assign in_ready   = (r_count < c_cnt_full) | (out_valid & out_ready);
    assign w_push     = in_valid & in_ready & ~flush;
    assign w_pop      = out_valid & out_ready & ~flush;
    assign illegal_op = r_illegal;

    // Outputs come only from stored entries, gated to zero when empty.
    assign EXTout = out_valid ? r_ext_mem[r_rd_ptr] : '0;
    assign NPC_B  = out_valid ? r_npc_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - 1'b1;
                end
            end
            if (w_push && w_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ext_mem[r_wr_ptr] <= w_ext;
            r_npc_mem[r_wr_ptr] <= w_npc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_ext_stage
// Description : Scoreboard bench for imm_ext_stage with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_ext_stage;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr_D;
    logic [DATA_W-1:0] PC4_D;
    logic [2:0]        ExtOp;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] EXTout;
    logic [DATA_W-1:0] NPC_B;
    logic              illegal_op;

    logic [31:0] r_cur_ext;
    logic [31:0] r_cur_npc;
    logic [63:0] q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    imm_ext_stage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr_D    (instr_D),
        .PC4_D      (PC4_D),
        .ExtOp      (ExtOp),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .EXTout     (EXTout),
        .NPC_B      (NPC_B),
        .illegal_op (illegal_op)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [2:0] op, input logic [31:0] e_ext, input logic [31:0] e_npc);
        in_valid  = v;
        instr_D   = ins;
        PC4_D     = pc;
        ExtOp     = op;
        r_cur_ext = e_ext;
        r_cur_npc = e_npc;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop/compare on each observed transfer, then record accepted input.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset) begin
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("EXTout", {32'h0, EXTout}, {32'h0, e[63:32]});
                        chk("NPC_B", {32'h0, NPC_B}, {32'h0, e[31:0]});
                    end
                end
                if (in_valid && in_ready) begin
                    q.push_back({r_cur_ext, r_cur_npc});
                end
            end
            if (!out_valid) begin
                chk("idle_zero", {EXTout, NPC_B}, 64'h0);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle();
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_EXTout", EXTout, 0);
        chk("rst_NPC_B", NPC_B, 0);
        chk("rst_illegal", illegal_op, 0);
        step();
        reset = 1'b0;

        // Single entry into empty buffer: visible one cycle after acceptance
        drive(1'b1, 32'h2401_8000, 32'h0000_3004, 3'b010, 32'hFFFF_8000, 32'hFFFF_B004);
        step();
        chk("latency_out_valid", out_valid, 1);
        idle();
        step();
        step();

        // Back-to-back stream across all legal modes
        drive(1'b1, 32'h2401_FFFF, 32'h0000_3004, 3'b011, 32'hFFFF_FFFC, 32'h0000_3000); step();
        drive(1'b1, 32'h0800_0C01, 32'h0040_0008, 3'b100, 32'h0000_3004, 32'h0000_3004); step();
        drive(1'b1, 32'h3401_8000, 32'h0000_0100, 3'b000, 32'h0000_8000, 32'h0000_8100); step();
        drive(1'b1, 32'h3C01_1234, 32'h0000_0010, 3'b001, 32'h1234_0000, 32'h1234_0010); step();
        drive(1'b1, 32'h3C01_8001, 32'hF000_0000, 3'b001, 32'h8001_0000, 32'h7001_0000); step();
        drive(1'b1, 32'h0BFF_FFFF, 32'hA000_0000, 3'b100, 32'hAFFF_FFFC, 32'hAFFF_FFFC); step();
        idle();
        step(); step(); step();

        // Backpressure: fill, stall a third push, then push+pop while full
        out_ready = 1'b0;
        drive(1'b1, 32'h3401_8000, 32'h0000_0100, 3'b000, 32'h0000_8000, 32'h0000_8100); step();
        drive(1'b1, 32'h3C01_1234, 32'h0000_0010, 3'b001, 32'h1234_0000, 32'h1234_0010); step();
        chk("full_in_ready", in_ready, 0);
        drive(1'b1, 32'h3C01_8001, 32'hF000_0000, 3'b001, 32'h8001_0000, 32'h7001_0000); step();
        chk("held_EXTout", EXTout, 32'h0000_8000);
        chk("held_NPC_B", NPC_B, 32'h0000_8100);
        chk("full_in_ready_2", in_ready, 0);
        step();
        chk("held_EXTout_2", EXTout, 32'h0000_8000);
        out_ready = 1'b1;
        #1;
        chk("pushpop_in_ready", in_ready, 1);
        step();
        idle();
        step(); step(); step();
        chk("drain_after_bp", q.size(), 0);

        // Flush with two entries and an incoming one
        out_ready = 1'b0;
        drive(1'b1, 32'h2401_8000, 32'h0000_3004, 3'b010, 32'hFFFF_8000, 32'hFFFF_B004); step();
        drive(1'b1, 32'h2401_FFFF, 32'h0000_3004, 3'b011, 32'hFFFF_FFFC, 32'h0000_3000); step();
        drive(1'b1, 32'h0800_0C01, 32'h0040_0008, 3'b100, 32'h0000_3004, 32'h0000_3004);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        step();
        chk("flush_dropped", out_valid, 0);
        out_ready = 1'b1;

        // Undefined ExtOp: zero results, sticky flag survives flush
        drive(1'b1, 32'h3C01_1234, 32'h0000_0500, 3'b110, 32'h0, 32'h0);
        step();
        chk("illegal_set", illegal_op, 1);
        chk("illegal_out_valid", out_valid, 1);
        idle();
        step();
        out_ready = 1'b0;
        drive(1'b1, 32'h2401_8000, 32'h0000_3004, 3'b010, 32'hFFFF_8000, 32'hFFFF_B004); step();
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("illegal_sticky", illegal_op, 1);
        chk("illegal_flush_empty", out_valid, 0);

        // Asynchronous reset mid-stream
        drive(1'b1, 32'h2401_FFFF, 32'h0000_3004, 3'b011, 32'hFFFF_FFFC, 32'h0000_3000); step();
        drive(1'b1, 32'h0800_0C01, 32'h0040_0008, 3'b100, 32'h0000_3004, 32'h0000_3004); step();
        chk("pre_reset_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_EXTout", EXTout, 0);
        chk("arst_NPC_B", NPC_B, 0);
        chk("arst_illegal", illegal_op, 0);
        chk("arst_in_ready", in_ready, 1);
        q.delete();
        idle();
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        drive(1'b1, 32'h2401_8000, 32'h0000_3004, 3'b010, 32'hFFFF_8000, 32'hFFFF_B004);
        step();
        chk("post_reset_accept", out_valid, 1);
        idle();
        step(); step();
        chk("final_drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_ext_stage.md
IMM_EXT_STAGE -- requirements
Module: imm_ext_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of EXTout/NPC_B/PC4 (legal: 32, 64).
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries (legal: 1..4).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  D-stage holds a valid instruction.
REQ-006 SHALL have port in_ready  output  1  buffer can accept this cycle.
REQ-007 SHALL have port instr_D  input  32  instruction word; imm = instr_D[15:0], jump index = instr_D[25:0].
REQ-008 SHALL have port PC4_D  input  DATA_W  PC+4 of that instruction.
REQ-009 SHALL have port ExtOp  input  3  mode selector (REQ-016).
REQ-010 SHALL have port flush  input  1  discard all buffered and incoming entries.
REQ-011 SHALL have port out_valid  output  1  head entry is valid.
REQ-012 SHALL have port out_ready  input  1  E stage consumes head.
REQ-013 SHALL have port EXTout  output  DATA_W  extended immediate of head.
REQ-014 SHALL have port NPC_B  output  DATA_W  target address of head.
REQ-015 SHALL have port illegal_op  output  1  sticky, set on acceptance of an undefined ExtOp.

Function
REQ-016 SHALL decode ExtOp: 000 zero-low, 001 high (imm<<16, zero-filled low; sign-extended above bit 31 when DATA_W>32), 010 sign-low, 011 sign-shift2 (sign-extended imm<<2), 100 jump ({PC4_D[DATA_W-1:28], instr_D[25:0], 2'b00}); 101-111 undefined.
REQ-017 SHALL compute NPC_B = PC4_D + EXTout mod 2^DATA_W for modes 000-011, NPC_B = EXTout for mode 100, EXTout = NPC_B = 0 for undefined modes.
REQ-018 SHALL compute EXTout/NPC_B combinationally at input and store the results with the entry; outputs SHALL be driven from buffer state only (no combinational in-to-out path).
REQ-019 SHALL accept an entry when in_valid & in_ready & !flush; latency from acceptance to out_valid SHALL be exactly 1 cycle when the buffer was empty.
REQ-020 SHALL pop the head when out_valid & out_ready & !flush.
REQ-021 SHALL assert in_ready = (count < DEPTH) | (out_valid & out_ready); a push and pop in the same cycle with the buffer full SHALL succeed with count unchanged.
REQ-022 SHALL preserve FIFO order; a head held under !out_ready SHALL keep EXTout/NPC_B stable.
REQ-023 SHALL, on flush, set count to 0 at the next edge and ignore same-cycle push and pop.
REQ-024 SHALL drive EXTout = NPC_B = 0 when out_valid = 0.
REQ-025 SHALL set illegal_op on acceptance of ExtOp 101-111 and hold it until reset; flush SHALL NOT clear it.
REQ-026 SHALL wrap read/write pointers modulo DEPTH.

Reset
REQ-027 SHALL, on reset assertion, immediately clear count, pointers, out_valid=0, EXTout=0, NPC_B=0, illegal_op=0, in_ready=1, regardless of clock.
REQ-028 SHALL discard any in-flight transfer when reset asserts mid-operation; the first acceptance occurs on the first rising edge after deassertion.

Structure
REQ-029 SHALL place ExtOp encodings and the DATA_W default as constants in the shared CPU package used by the controller.
REQ-030 SHALL isolate the combinational decode/add in one sub-module imm_ext_core; buffer and control SHALL reside in imm_ext_stage.

Verification
REQ-031 SHALL cover: ExtOp=010, imm=0x8000, PC4=0x00003004 -> next cycle EXTout=0xFFFF8000, NPC_B=0xFFFFB004.
REQ-032 SHALL cover: ExtOp=011, imm=0xFFFF, PC4=0x00003004 -> EXTout=0xFFFFFFFC, NPC_B=0x00003000; ExtOp=100, instr[25:0]=0x0000C01, PC4=0x00400008 -> NPC_B=0x00003004.
REQ-033 SHALL cover: out_ready=0, three pushes (DEPTH=2) -> in_ready=0 after two, head stable; then out_ready=1 with push -> in-order output, no loss.
REQ-034 SHALL cover: flush with 2 entries and in_valid=1 -> next cycle out_valid=0, count=0, incoming entry dropped.
REQ-035 SHALL cover: ExtOp=110 accepted -> EXTout=NPC_B=0, illegal_op=1 persisting across flush; reset asserted mid-stream -> all outputs 0 asynchronously.
